// File: rtl/dcache_line_ctrl_if.sv
// Bundle between the data-cache miss sequencer, the cache tag/data arrays and the D-memory SRAM.
// The tag side is the master of the request; the sequencer sits on the slave modport.
interface dcache_line_ctrl_if #(
  parameter int IDX_W  = 2,
  parameter int AWIDTH = 12,
  parameter int DWIDTH = 32
);
  logic              REQ_VALID;
  logic              REQ_DIRTY;
  logic [AWIDTH-1:0] REQ_FILL_ADDR;
  logic [AWIDTH-1:0] REQ_VICT_ADDR;
  logic              REQ_READY;
  logic [IDX_W-1:0]  VICT_RD_IDX;
  logic [DWIDTH-1:0] VICT_RD_DATA;
  logic              FILL_WE;
  logic [IDX_W-1:0]  FILL_IDX;
  logic [DWIDTH-1:0] FILL_DATA;
  logic              DONE;
  logic              D_MEM_CSN;
  logic              D_MEM_WEN;
  logic [3:0]        D_MEM_BE;
  logic [AWIDTH-1:0] D_MEM_ADDR;
  logic [DWIDTH-1:0] D_MEM_DOUT;
  logic [DWIDTH-1:0] D_MEM_DI;
  logic [31:0]       MISS_CNT;
  logic [31:0]       WB_CNT;

  modport master (
    output REQ_VALID, REQ_DIRTY, REQ_FILL_ADDR, REQ_VICT_ADDR, VICT_RD_DATA, D_MEM_DI,
    input  REQ_READY, VICT_RD_IDX, FILL_WE, FILL_IDX, FILL_DATA, DONE,
           D_MEM_CSN, D_MEM_WEN, D_MEM_BE, D_MEM_ADDR, D_MEM_DOUT, MISS_CNT, WB_CNT
  );

  modport slave (
    input  REQ_VALID, REQ_DIRTY, REQ_FILL_ADDR, REQ_VICT_ADDR, VICT_RD_DATA, D_MEM_DI,
    output REQ_READY, VICT_RD_IDX, FILL_WE, FILL_IDX, FILL_DATA, DONE,
           D_MEM_CSN, D_MEM_WEN, D_MEM_BE, D_MEM_ADDR, D_MEM_DOUT, MISS_CNT, WB_CNT
  );
endinterface

// File: rtl/dcache_line_ctrl.sv
// Data-cache miss sequencer: writes back a dirty victim line, refills the missing line from
// D-memory into the cache data array, pulses DONE, and counts misses and writebacks.
module dcache_line_ctrl #(
  parameter int WORDS_PER_LINE = 4,
  parameter int IDX_W          = 2,
  parameter int AWIDTH         = 12,
  parameter int DWIDTH         = 32
) (
  input  logic               CLK,
  input  logic               RSTn,
  dcache_line_ctrl_if.slave  bus
);

  typedef enum logic [2:0] {S_IDLE, S_WB, S_RD, S_FILL, S_DONE} state_t;

  localparam logic [IDX_W-1:0]  LAST      = IDX_W'(WORDS_PER_LINE - 1);
  localparam logic [AWIDTH-1:0] LINE_MASK = ~AWIDTH'(WORDS_PER_LINE - 1);

  state_t            state, state_nxt;
  logic [IDX_W-1:0]  cnt, cnt_nxt;
  logic [IDX_W-1:0]  fill_idx_q;
  logic              fill_pend;
  logic [AWIDTH-1:0] fill_base, vict_base;
  logic [31:0]       miss_cnt, wb_cnt;
  logic              accept;

  // NOTE: every signal written here gets a default first, so no path can leave one unassigned
  // and infer a latch.
  always_comb begin
    state_nxt          = state;
    cnt_nxt            = cnt;
    accept             = 1'b0;
    bus.REQ_READY      = 1'b0;
    bus.D_MEM_CSN      = 1'b1;
    bus.D_MEM_WEN      = 1'b1;
    bus.D_MEM_BE       = 4'b0000;
    bus.D_MEM_ADDR     = '0;
    bus.D_MEM_DOUT     = '0;
    bus.VICT_RD_IDX    = '0;
    bus.DONE           = 1'b0;
    case (state)
      S_IDLE: begin
        bus.REQ_READY = 1'b1;
        if (bus.REQ_VALID) begin
          accept    = 1'b1;
          cnt_nxt   = '0;
          state_nxt = bus.REQ_DIRTY ? S_WB : S_RD;
        end
      end
      S_WB: begin
        bus.D_MEM_CSN   = 1'b0;
        bus.D_MEM_WEN   = 1'b0;
        bus.D_MEM_BE    = 4'b1111;
        bus.D_MEM_ADDR  = vict_base | AWIDTH'(cnt);
        bus.VICT_RD_IDX = cnt;
        bus.D_MEM_DOUT  = bus.VICT_RD_DATA;
        cnt_nxt         = cnt + IDX_W'(1);
        if (cnt == LAST) begin
          cnt_nxt   = '0;
          state_nxt = S_RD;
        end
      end
      S_RD: begin
        bus.D_MEM_CSN  = 1'b0;
        bus.D_MEM_ADDR = fill_base | AWIDTH'(cnt);
        cnt_nxt        = cnt + IDX_W'(1);
        if (cnt == LAST) begin
          cnt_nxt   = '0;
          state_nxt = S_FILL;
        end
      end
      S_FILL:  state_nxt = S_DONE;
      S_DONE: begin
        bus.DONE  = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state      <= S_IDLE;
      cnt        <= '0;
      fill_pend  <= 1'b0;
      fill_idx_q <= '0;
      fill_base  <= '0;
      vict_base  <= '0;
      miss_cnt   <= '0;
      wb_cnt     <= '0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      fill_pend  <= (state == S_RD);
      fill_idx_q <= cnt;
      if (accept) begin
        fill_base <= bus.REQ_FILL_ADDR & LINE_MASK;
        vict_base <= bus.REQ_VICT_ADDR & LINE_MASK;
        miss_cnt  <= miss_cnt + 32'd1;
        wb_cnt    <= wb_cnt + 32'(bus.REQ_DIRTY);
      end
    end
  end

  // SRAM read data arrives one cycle after the RD cycle that addressed it.
  assign bus.FILL_WE   = fill_pend;
  assign bus.FILL_IDX  = fill_pend ? fill_idx_q : '0;
  assign bus.FILL_DATA = fill_pend ? bus.D_MEM_DI : '0;
  assign bus.MISS_CNT  = miss_cnt;
  assign bus.WB_CNT    = wb_cnt;

endmodule

// File: tb/tb_dcache_line_ctrl.sv
// Directed bench for dcache_line_ctrl: SRAM and victim-array models around the DUT,
// one task per scenario with hand-computed cycle-by-cycle expectations.
module tb_dcache_line_ctrl;
  localparam int N  = 4;
  localparam int IW = 2;
  localparam int AW = 12;
  localparam int DW = 32;
  localparam logic [88:0] RST_VEC = {1'b1, 1'b1, 1'b1, 4'b0000, 12'h000, 32'h0,
                                     1'b0, 2'b00, 32'h0, 2'b00, 1'b0};

  logic CLK  = 1'b0;
  logic RSTn = 1'b0;
  int   checks   = 0;
  int   failures = 0;

  always #5 CLK = ~CLK;

  dcache_line_ctrl_if #(.IDX_W(IW), .AWIDTH(AW), .DWIDTH(DW)) bus ();

  dcache_line_ctrl #(.WORDS_PER_LINE(N), .IDX_W(IW), .AWIDTH(AW), .DWIDTH(DW)) dut (
    .CLK  (CLK),
    .RSTn (RSTn),
    .bus  (bus)
  );

  // SRAM model: unwritten words read back as a fixed address pattern.
  logic [31:0] mem     [0:4095];
  logic        written [0:4095];
  logic [31:0] rdata = '0;
  logic [31:0] vict  [0:N-1];

  function automatic logic [31:0] pattern(input logic [11:0] a);
    return 32'hA000_0000 | {20'h0, a};
  endfunction

  function automatic logic [31:0] mem_word(input logic [11:0] a);
    return written[a] ? mem[a] : pattern(a);
  endfunction

  always @(posedge CLK) begin
    if (!bus.D_MEM_CSN) begin
      if (!bus.D_MEM_WEN) begin
        for (int b = 0; b < 4; b++)
          if (bus.D_MEM_BE[b]) mem[bus.D_MEM_ADDR][8*b +: 8] <= bus.D_MEM_DOUT[8*b +: 8];
        written[bus.D_MEM_ADDR] <= 1'b1;
      end else begin
        rdata <= mem_word(bus.D_MEM_ADDR);
      end
    end
  end

  assign bus.D_MEM_DI     = rdata;
  assign bus.VICT_RD_DATA = vict[bus.VICT_RD_IDX];

  function automatic logic [88:0] obs_all();
    return {bus.REQ_READY, bus.D_MEM_CSN, bus.D_MEM_WEN, bus.D_MEM_BE, bus.D_MEM_ADDR,
            bus.D_MEM_DOUT, bus.FILL_WE, bus.FILL_IDX, bus.FILL_DATA, bus.VICT_RD_IDX, bus.DONE};
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Present a request in IDLE for one accept edge; returns in cycle 1.
  task automatic issue(input logic dirty, input logic [11:0] fill, input logic [11:0] va);
    bus.REQ_VALID     = 1'b1;
    bus.REQ_DIRTY     = dirty;
    bus.REQ_FILL_ADDR = fill;
    bus.REQ_VICT_ADDR = va;
    tick();
    bus.REQ_VALID     = 1'b0;
  endtask

  task automatic test_power_on();
    #1;
    checks++;
    if (obs_all() !== RST_VEC) begin
      failures++;
      $display("FAIL power_on_outputs got=%h exp=%h", obs_all(), RST_VEC);
    end
    tick();
    tick();
    RSTn = 1'b1;
    checks++;
    if ({bus.MISS_CNT, bus.WB_CNT, bus.REQ_READY} !== {32'd0, 32'd0, 1'b1}) begin
      failures++;
      $display("FAIL power_on_counters got=%h/%h rdy=%b exp=0/0 rdy=1",
               bus.MISS_CNT, bus.WB_CNT, bus.REQ_READY);
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < N; i++) vict[i] = 32'h5EED_0000 + i;
    issue(1'b1, 12'h200, 12'h3BC);
    tick();
    tick();
    checks++;
    if ({bus.D_MEM_CSN, bus.D_MEM_ADDR} !== {1'b0, 12'h3BE}) begin
      failures++;
      $display("FAIL reset_pre_wb2 got=%b/%h exp=0/3be", bus.D_MEM_CSN, bus.D_MEM_ADDR);
    end
    #2;
    RSTn = 1'b0;
    #1;
    checks++;
    if (obs_all() !== RST_VEC) begin
      failures++;
      $display("FAIL reset_async_outputs got=%h exp=%h", obs_all(), RST_VEC);
    end
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++;
      if (obs_all() !== RST_VEC) begin
        failures++;
        $display("FAIL reset_held c=%0d got=%h exp=%h", c, obs_all(), RST_VEC);
      end
    end
    RSTn = 1'b1;
    checks++;
    if ({bus.REQ_READY, bus.MISS_CNT, bus.WB_CNT} !== {1'b1, 32'd0, 32'd0}) begin
      failures++;
      $display("FAIL reset_release got rdy=%b miss=%0d wb=%0d exp rdy=1 miss=0 wb=0",
               bus.REQ_READY, bus.MISS_CNT, bus.WB_CNT);
    end
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++;
      if (bus.D_MEM_CSN !== 1'b1) begin
        failures++;
        $display("FAIL reset_no_access c=%0d got csn=%b exp=1", c, bus.D_MEM_CSN);
      end
    end
    checks++;
    if ({written[12'h3BC], written[12'h3BD], written[12'h3BE], mem[12'h3BC], mem[12'h3BD]} !==
        {3'b110, 32'h5EED_0000, 32'h5EED_0001}) begin
      failures++;
      $display("FAIL reset_partial_wb got wr=%b%b%b m0=%h m1=%h exp wr=110 m0=5eed0000 m1=5eed0001",
               written[12'h3BC], written[12'h3BD], written[12'h3BE], mem[12'h3BC], mem[12'h3BD]);
    end
  endtask

  task automatic test_clean_miss();
    issue(1'b0, 12'h0E5, 12'h000);
    for (int c = 1; c <= 7; c++) begin
      if (c <= 4) begin
        checks++;
        if ({bus.D_MEM_CSN, bus.D_MEM_WEN, bus.D_MEM_BE, bus.D_MEM_ADDR} !==
            {1'b0, 1'b1, 4'b0000, 12'(12'h0E4 + c - 1)}) begin
          failures++;
          $display("FAIL clean_rd c=%0d got csn=%b wen=%b be=%b addr=%h exp 0/1/0000/%h", c,
                   bus.D_MEM_CSN, bus.D_MEM_WEN, bus.D_MEM_BE, bus.D_MEM_ADDR, 12'(12'h0E4 + c - 1));
        end
      end else begin
        checks++;
        if (bus.D_MEM_CSN !== 1'b1) begin
          failures++;
          $display("FAIL clean_csn_idle c=%0d got=%b exp=1", c, bus.D_MEM_CSN);
        end
      end
      if (c >= 2 && c <= 5) begin
        checks++;
        if ({bus.FILL_WE, bus.FILL_IDX, bus.FILL_DATA} !==
            {1'b1, 2'(c - 2), pattern(12'(12'h0E4 + c - 2))}) begin
          failures++;
          $display("FAIL clean_fill c=%0d got we=%b idx=%0d data=%h exp 1/%0d/%h", c,
                   bus.FILL_WE, bus.FILL_IDX, bus.FILL_DATA, c - 2, pattern(12'(12'h0E4 + c - 2)));
        end
      end else begin
        checks++;
        if (bus.FILL_WE !== 1'b0) begin
          failures++;
          $display("FAIL clean_fill_idle c=%0d got we=%b exp=0", c, bus.FILL_WE);
        end
      end
      checks++;
      if ({bus.DONE, bus.REQ_READY} !== ((c == 6) ? 2'b10 : (c == 7) ? 2'b01 : 2'b00)) begin
        failures++;
        $display("FAIL clean_done c=%0d got done=%b rdy=%b", c, bus.DONE, bus.REQ_READY);
      end
      if (c < 7) tick();
    end
    checks++;
    if ({bus.MISS_CNT, bus.WB_CNT} !== {32'd1, 32'd0}) begin
      failures++;
      $display("FAIL clean_counters got miss=%0d wb=%0d exp miss=1 wb=0", bus.MISS_CNT, bus.WB_CNT);
    end
  endtask

  task automatic test_dirty_miss();
    for (int i = 0; i < N; i++) vict[i] = 32'hDEAD_B000 + 32'(i * 17);
    issue(1'b1, 12'h2A6, 12'h3BD);
    for (int c = 1; c <= 11; c++) begin
      if (c <= 4) begin
        checks++;
        if ({bus.D_MEM_CSN, bus.D_MEM_WEN, bus.D_MEM_BE, bus.D_MEM_ADDR, bus.VICT_RD_IDX,
             bus.D_MEM_DOUT} !== {1'b0, 1'b0, 4'b1111, 12'(12'h3BC + c - 1), 2'(c - 1), vict[c-1]}) begin
          failures++;
          $display("FAIL dirty_wb c=%0d got csn=%b wen=%b be=%b addr=%h idx=%0d dout=%h exp 0/0/1111/%h/%0d/%h",
                   c, bus.D_MEM_CSN, bus.D_MEM_WEN, bus.D_MEM_BE, bus.D_MEM_ADDR, bus.VICT_RD_IDX,
                   bus.D_MEM_DOUT, 12'(12'h3BC + c - 1), c - 1, vict[c-1]);
        end
      end else if (c <= 8) begin
        checks++;
        if ({bus.D_MEM_CSN, bus.D_MEM_WEN, bus.D_MEM_BE, bus.D_MEM_ADDR} !==
            {1'b0, 1'b1, 4'b0000, 12'(12'h2A4 + c - 5)}) begin
          failures++;
          $display("FAIL dirty_rd c=%0d got csn=%b wen=%b addr=%h exp 0/1/%h", c,
                   bus.D_MEM_CSN, bus.D_MEM_WEN, bus.D_MEM_ADDR, 12'(12'h2A4 + c - 5));
        end
      end else begin
        checks++;
        if (bus.D_MEM_CSN !== 1'b1) begin
          failures++;
          $display("FAIL dirty_csn_idle c=%0d got=%b exp=1", c, bus.D_MEM_CSN);
        end
      end
      checks++;
      if (c >= 6 && c <= 9) begin
        if ({bus.FILL_WE, bus.FILL_IDX, bus.FILL_DATA} !==
            {1'b1, 2'(c - 6), pattern(12'(12'h2A4 + c - 6))}) begin
          failures++;
          $display("FAIL dirty_fill c=%0d got we=%b idx=%0d data=%h exp 1/%0d/%h", c,
                   bus.FILL_WE, bus.FILL_IDX, bus.FILL_DATA, c - 6, pattern(12'(12'h2A4 + c - 6)));
        end
      end else if (bus.FILL_WE !== 1'b0) begin
        failures++;
        $display("FAIL dirty_fill_idle c=%0d got we=%b exp=0", c, bus.FILL_WE);
      end
      checks++;
      if ({bus.DONE, bus.REQ_READY} !== ((c == 10) ? 2'b10 : (c == 11) ? 2'b01 : 2'b00)) begin
        failures++;
        $display("FAIL dirty_done c=%0d got done=%b rdy=%b", c, bus.DONE, bus.REQ_READY);
      end
      if (c < 11) tick();
    end
    for (int i = 0; i < N; i++) begin
      checks++;
      if (mem_word(12'(12'h3BC + i)) !== vict[i]) begin
        failures++;
        $display("FAIL dirty_mem i=%0d got=%h exp=%h", i, mem_word(12'(12'h3BC + i)), vict[i]);
      end
    end
    checks++;
    if ({bus.MISS_CNT, bus.WB_CNT} !== {32'd2, 32'd1}) begin
      failures++;
      $display("FAIL dirty_counters got miss=%0d wb=%0d exp miss=2 wb=1", bus.MISS_CNT, bus.WB_CNT);
    end
  endtask

  task automatic test_same_line();
    for (int i = 0; i < N; i++) vict[i] = 32'hC0DE_0100 + 32'(i);
    issue(1'b1, 12'h102, 12'h101);
    for (int c = 1; c <= 10; c++) begin
      if (c >= 6 && c <= 9) begin
        checks++;
        if ({bus.FILL_WE, bus.FILL_IDX, bus.FILL_DATA} !== {1'b1, 2'(c - 6), vict[c-6]}) begin
          failures++;
          $display("FAIL same_line_fill c=%0d got we=%b idx=%0d data=%h exp 1/%0d/%h", c,
                   bus.FILL_WE, bus.FILL_IDX, bus.FILL_DATA, c - 6, vict[c-6]);
        end
      end
      if (c == 10) begin
        checks++;
        if (bus.DONE !== 1'b1) begin
          failures++;
          $display("FAIL same_line_done got=%b exp=1", bus.DONE);
        end
      end
      tick();
    end
    checks++;
    if ({bus.MISS_CNT, bus.WB_CNT} !== {32'd3, 32'd2}) begin
      failures++;
      $display("FAIL same_line_counters got miss=%0d wb=%0d exp miss=3 wb=2", bus.MISS_CNT, bus.WB_CNT);
    end
  endtask

  task automatic test_back_to_back();
    bus.REQ_VALID     = 1'b1;
    bus.REQ_DIRTY     = 1'b0;
    bus.REQ_FILL_ADDR = 12'h0E5;
    bus.REQ_VICT_ADDR = 12'h3BC;
    tick();
    for (int c = 1; c <= 7; c++) begin
      checks++;
      if (bus.REQ_READY !== (c == 7)) begin
        failures++;
        $display("FAIL b2b_ready c=%0d got=%b exp=%b", c, bus.REQ_READY, c == 7);
      end
      if (c < 7) tick();
    end
    checks++;
    if (bus.MISS_CNT !== 32'd4) begin
      failures++;
      $display("FAIL b2b_busy_not_counted got=%0d exp=4", bus.MISS_CNT);
    end
    tick();
    bus.REQ_VALID = 1'b0;
    checks++;
    if ({bus.REQ_READY, bus.D_MEM_CSN, bus.D_MEM_ADDR} !== {1'b0, 1'b0, 12'h0E4}) begin
      failures++;
      $display("FAIL b2b_second_accept got rdy=%b csn=%b addr=%h exp 0/0/0e4",
               bus.REQ_READY, bus.D_MEM_CSN, bus.D_MEM_ADDR);
    end
    for (int c = 8; c <= 14; c++) begin
      if (c >= 13) begin
        checks++;
        if ({bus.DONE, bus.REQ_READY} !== ((c == 13) ? 2'b10 : 2'b01)) begin
          failures++;
          $display("FAIL b2b_done c=%0d got done=%b rdy=%b", c, bus.DONE, bus.REQ_READY);
        end
      end
      if (c < 14) tick();
    end
    checks++;
    if ({bus.MISS_CNT, bus.WB_CNT} !== {32'd5, 32'd2}) begin
      failures++;
      $display("FAIL b2b_counters got miss=%0d wb=%0d exp miss=5 wb=2", bus.MISS_CNT, bus.WB_CNT);
    end
  endtask

  task automatic test_counter_wrap();
    force dut.miss_cnt = 32'hFFFF_FFFF;
    #1;
    release dut.miss_cnt;
    #1;
    checks++;
    if (bus.MISS_CNT !== 32'hFFFF_FFFF) begin
      failures++;
      $display("FAIL wrap_preset got=%h exp=ffffffff", bus.MISS_CNT);
    end
    tick();
    issue(1'b0, 12'h010, 12'h000);
    checks++;
    if ({bus.MISS_CNT, bus.WB_CNT} !== {32'd0, 32'd2}) begin
      failures++;
      $display("FAIL wrap_counters got miss=%h wb=%0d exp miss=0 wb=2", bus.MISS_CNT, bus.WB_CNT);
    end
    for (int c = 1; c <= 6; c++) tick();
    checks++;
    if (bus.REQ_READY !== 1'b1) begin
      failures++;
      $display("FAIL wrap_return_idle got=%b exp=1", bus.REQ_READY);
    end
  endtask

  initial begin
    for (int a = 0; a < 4096; a++) written[a] = 1'b0;
    for (int i = 0; i < N; i++) vict[i] = '0;
    bus.REQ_VALID     = 1'b0;
    bus.REQ_DIRTY     = 1'b0;
    bus.REQ_FILL_ADDR = '0;
    bus.REQ_VICT_ADDR = '0;
    test_power_on();
    test_reset();
    test_clean_miss();
    test_dirty_miss();
    test_same_line();
    test_back_to_back();
    test_counter_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog run did not finish checks=%0d", checks);
    $fatal(1, "watchdog");
  end

endmodule
